// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//
// Purpose:
//   Shared definitions for the universal shift register: the 2-bit mode type
//   and the mode-select constants decoded by every bit cell.
//
// Contents:
//   mode_t       2-bit mode select type
//   MODE_LOAD    parallel load from Data
//   MODE_SHR     shift toward the LSB, Left_Input enters at the MSB
//   MODE_SHL     shift toward the MSB, Right_Input enters at the LSB
//   MODE_HOLD    keep the current contents
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LOAD = 2'd0;
    localparam mode_t MODE_SHR  = 2'd1;
    localparam mode_t MODE_SHL  = 2'd2;
    localparam mode_t MODE_HOLD = 2'd3;

endpackage : shift_pkg

// File: rtl/shift_bit_cell.sv
// -----------------------------------------------------------------------------
// shift_bit_cell
//
// Purpose:
//   One bit position of the universal shift register: a 4:1 next-state mux
//   followed by a flip-flop with asynchronous active-low clear.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low clear of the stored bit
//   mode_i       mode select (shift_pkg::mode_t)
//   data_i       parallel load bit for this position
//   left_nbr_i   bit from the next-higher position (or Left_Input at the MSB)
//   right_nbr_i  bit from the next-lower position (or Right_Input at the LSB)
//   bit_o        stored bit
// -----------------------------------------------------------------------------
module shift_bit_cell
    import shift_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  mode_t mode_i,
    input  logic  data_i,
    input  logic  left_nbr_i,
    input  logic  right_nbr_i,
    output logic  bit_o
);

    logic bit_q;
    logic bit_d;

    // A right shift moves every bit one place toward the LSB, so each cell
    // takes the value of its left (higher) neighbour; a left shift is the
    // mirror image. Any unrecognised mode value falls back to holding.
    always_comb begin
        bit_d = bit_q;
        case (mode_i)
            MODE_LOAD: bit_d = data_i;
            MODE_SHR:  bit_d = left_nbr_i;
            MODE_SHL:  bit_d = right_nbr_i;
            MODE_HOLD: bit_d = bit_q;
            default:   bit_d = bit_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule : shift_bit_cell

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   Parallel-load, bidirectional shift register with serial fill at both ends
//   and a hold mode. The mode on LR is applied at every rising Clk edge;
//   Result always shows the registered contents.
//
// Parameters:
//   WIDTH        register width in bits (minimum 2)
//
// Ports:
//   Clk          rising-edge clock
//   Reset        asynchronous active-low reset; clears the register at once
//   Data         parallel load value (used only in LOAD)
//   LR           mode: 0 LOAD, 1 SHR, 2 SHL, 3 HOLD
//   Left_Input   serial bit entering the MSB on a right shift
//   Right_Input  serial bit entering the LSB on a left shift
//   Result       current register contents
// -----------------------------------------------------------------------------
module universal_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic [1:0]       LR,
    input  logic             Left_Input,
    input  logic             Right_Input,
    output logic [WIDTH-1:0] Result
);

    mode_t            mode;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] left_nbr;
    logic [WIDTH-1:0] right_nbr;

    assign mode = mode_t'(LR);

    // Neighbour wiring: the serial inputs stand in for the missing neighbour
    // at each end, so shifted-out bits simply fall off with no wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (gi == WIDTH - 1) begin : g_msb
                assign left_nbr[gi] = Left_Input;
            end else begin : g_mid_l
                assign left_nbr[gi] = result_q[gi+1];
            end

            if (gi == 0) begin : g_lsb
                assign right_nbr[gi] = Right_Input;
            end else begin : g_mid_r
                assign right_nbr[gi] = result_q[gi-1];
            end

            shift_bit_cell u_cell (
                .clk_i       (Clk),
                .rst_n_i     (Reset),
                .mode_i      (mode),
                .data_i      (Data[gi]),
                .left_nbr_i  (left_nbr[gi]),
                .right_nbr_i (right_nbr[gi]),
                .bit_o       (result_q[gi])
            );
        end
    endgenerate

    assign Result = result_q;

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Self-checking bench for universal_shift_reg (WIDTH = 8). A behavioural
// model tracks the expected register value with plain shift arithmetic;
// directed sequences also compare against literal values.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic [W-1:0] Data;
    logic [1:0]   LR;
    logic         Left_Input;
    logic         Right_Input;
    logic [W-1:0] Result;

    int           n_checks;
    int           n_errors;
    logic [W-1:0] model_val;

    universal_shift_reg #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Data        (Data),
        .LR          (LR),
        .Left_Input  (Left_Input),
        .Right_Input (Right_Input),
        .Result      (Result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end else begin
            $display("ok   %s: %b", tag, got);
        end
    endtask

    // Model: the register as an unsigned integer; shifts by arithmetic.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input int m,
                                                input logic [W-1:0] d, input logic li,
                                                input logic ri);
        int v;
        v = int'(cur);
        case (m)
            0: v = int'(d);
            1: v = (v / 2) + (li ? (1 << (W - 1)) : 0);
            2: v = ((v * 2) % (1 << W)) + (ri ? 1 : 0);
            default: v = v;
        endcase
        return v[W-1:0];
    endfunction

    // Drive one operation, wait for the edge, sample 1 time unit later.
    task automatic step(input logic [1:0] m, input logic [W-1:0] d, input logic li,
                        input logic ri, input string tag);
        LR = m; Data = d; Left_Input = li; Right_Input = ri;
        @(posedge Clk); #1;
        model_val = model_next(model_val, int'(m), d, li, ri);
        chk(tag, Result, model_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_val = '0;

        // Reset held low with a pending load: output must stay cleared.
        Reset = 1'b0; Data = 8'h32; LR = 2'd0; Left_Input = 1'b0; Right_Input = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            chk($sformatf("reset_hold%0d", i), Result, 8'h00);
        end
        Reset = 1'b1;

        // Load then right shift.
        step(2'd0, 8'b00110010, 1'b0, 1'b0, "load");
        chk("load_lit", Result, 8'b00110010);
        step(2'd1, 8'h00, 1'b1, 1'b0, "shr1");
        chk("shr1_lit", Result, 8'b10011001);

        // Left shift, then two right shifts.
        step(2'd2, 8'h00, 1'b0, 1'b1, "shl1");
        chk("shl1_lit", Result, 8'b00110011);
        step(2'd1, 8'h00, 1'b1, 1'b0, "shr2");
        chk("shr2_lit", Result, 8'b10011001);
        step(2'd1, 8'h00, 1'b1, 1'b0, "shr3");
        chk("shr3_lit", Result, 8'b11001100);

        // Hold while other inputs toggle, including a mid-cycle glitch on LR.
        for (int i = 0; i < 3; i++) begin
            LR = 2'd3; Data = W'($urandom); Left_Input = i[0]; Right_Input = ~i[0];
            #2 LR = 2'd0;
            #2 LR = 2'd3;
            @(posedge Clk); #1;
            chk($sformatf("hold%0d", i), Result, 8'b11001100);
        end
        step(2'd2, 8'h5A, 1'b0, 1'b1, "shl_after_hold");
        chk("shl_after_hold_lit", Result, 8'b10011001);

        // Asynchronous reset mid-cycle after a load.
        step(2'd0, 8'hA7, 1'b0, 1'b0, "load_pre_rst");
        #2 Reset = 1'b0;
        #1 chk("async_clear", Result, 8'h00);
        model_val = '0;
        LR = 2'd0; Data = 8'hFF;
        @(posedge Clk); #1;
        chk("rst_low_edge", Result, 8'h00);
        Reset = 1'b1;

        // Fill with ones from the left, flush with zeros from the right.
        step(2'd0, 8'h00, 1'b0, 1'b0, "fill_load");
        for (int i = 0; i < W; i++)
            step(2'd1, W'($urandom), 1'b1, 1'($urandom), $sformatf("fill%0d", i));
        chk("fill_lit", Result, 8'hFF);
        for (int i = 0; i < W; i++)
            step(2'd2, W'($urandom), 1'($urandom), 1'b0, $sformatf("flush%0d", i));
        chk("flush_lit", Result, 8'h00);

        // Serial inputs ignored in LOAD; Data and Right_Input ignored in SHR.
        for (int i = 0; i < 3; i++)
            step(2'd0, W'($urandom), 1'($urandom), 1'($urandom), $sformatf("load_ign%0d", i));
        for (int i = 0; i < 4; i++)
            step(2'd1, W'($urandom), i[0], ~i[0], $sformatf("shr_ign%0d", i));

        // Randomised operation mix with occasional asynchronous reset pulses.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 Reset = 1'b0;
                #1 chk($sformatf("rnd_rst%0d", i), Result, 8'h00);
                model_val = '0;
                @(posedge Clk); #1;
                Reset = 1'b1;
            end
            step(2'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                 $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_universal_shift_reg
